// File: rtl/multiplier_unit.sv
// multiplier_unit
// Iterative RV32M multiplier for MUL, MULH, MULHSU and MULHU. One radix-2
// shift-add step per cycle on a 64-bit accumulator; busy stays high for
// 32 CALC cycles plus one FINISH cycle. A completed operation is recorded
// so that operands held on the inputs do not retrigger the unit.
//
// Ports:
//   CLK              rising-edge clock
//   reset            synchronous, active-high reset
//   opcode           instruction opcode (0110011 = R-type)
//   funct7           0000001 = M-extension
//   funct3           000 MUL, 001 MULH, 010 MULHSU, 011 MULHU; 1xx ignored
//   accuracy_control [0] approximate enable, [10:3] multiplicand low-bit mask
//   rs1              multiplicand
//   rs2              multiplier
//   mul_unit_busy    high while an operation is in flight
//   mul_output       result; holds the last completed value
module multiplier_unit #(
    parameter int unsigned XLEN  = 32,
    parameter int unsigned STEPS = 32
) (
    input  logic            CLK,
    input  logic            reset,
    input  logic [6:0]      opcode,
    input  logic [6:0]      funct7,
    input  logic [2:0]      funct3,
    input  logic [31:0]     accuracy_control,
    input  logic [XLEN-1:0] rs1,
    input  logic [XLEN-1:0] rs2,
    output logic            mul_unit_busy,
    output logic [XLEN-1:0] mul_output
);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_CALC   = 2'd1;
    localparam logic [1:0] S_FINISH = 2'd2;

    localparam int unsigned    CW        = $clog2(STEPS);
    localparam logic [CW-1:0]  LAST_STEP = CW'(STEPS - 1);

    logic [1:0]        state_q, state_d;
    logic [CW-1:0]     count_q, count_d;
    logic              busy_q, busy_d;
    logic [XLEN-1:0]   out_q, out_d;
    logic              rec_valid_q, rec_valid_d;
    logic [2:0]        rec_f3_q, rec_f3_d;
    logic [XLEN-1:0]   rec_rs1_q, rec_rs1_d;
    logic [XLEN-1:0]   rec_rs2_q, rec_rs2_d;
    logic [10:0]       rec_acc_q, rec_acc_d;
    logic [XLEN-1:0]   mcand_q, mcand_d;
    logic [2*XLEN-1:0] prod_q, prod_d;
    logic              neg_q, neg_d;

    logic              valid_op;
    logic              same_as_rec;
    logic              start;
    logic              rs1_neg, rs2_neg;
    logic [XLEN-1:0]   rs1_mag, rs2_mag;
    logic [XLEN-1:0]   mcand_eff;
    logic [XLEN:0]     step_sum;
    logic [2*XLEN-1:0] prod_step;
    logic [2*XLEN-1:0] prod_signed;
    logic              unused_bits;

    assign unused_bits = ^{accuracy_control[31:11], accuracy_control[2:1]};

    always_comb begin
        valid_op    = (opcode == 7'b0110011) && (funct7 == 7'b0000001) && !funct3[2];
        same_as_rec = rec_valid_q &&
                      ({funct3, rs1, rs2, accuracy_control[10:0]} ==
                       {rec_f3_q, rec_rs1_q, rec_rs2_q, rec_acc_q});
        start       = (state_q == S_IDLE) && valid_op && !same_as_rec;

        // rs1 is signed for MULH/MULHSU, rs2 only for MULH.
        rs1_neg = ((funct3 == 3'b001) || (funct3 == 3'b010)) && rs1[XLEN-1];
        rs2_neg = (funct3 == 3'b001) && rs2[XLEN-1];
        rs1_mag = rs1_neg ? (~rs1 + 1'b1) : rs1;
        rs2_mag = rs2_neg ? (~rs2 + 1'b1) : rs2;

        // Approximation truncates the magnitude, not the raw operand.
        mcand_eff = rs1_mag;
        if (accuracy_control[0]) begin
            mcand_eff[7:0] = rs1_mag[7:0] & accuracy_control[10:3];
        end

        // Low half of the accumulator holds the remaining multiplier bits;
        // each step adds into the high half and shifts the whole thing right.
        step_sum    = {1'b0, prod_q[2*XLEN-1:XLEN]} +
                      (prod_q[0] ? {1'b0, mcand_q} : {(XLEN+1){1'b0}});
        prod_step   = {step_sum, prod_q[XLEN-1:1]};
        prod_signed = neg_q ? (~prod_q + 1'b1) : prod_q;
    end

    always_comb begin
        state_d     = state_q;
        count_d     = count_q;
        busy_d      = busy_q;
        out_d       = out_q;
        rec_valid_d = rec_valid_q;
        rec_f3_d    = rec_f3_q;
        rec_rs1_d   = rec_rs1_q;
        rec_rs2_d   = rec_rs2_q;
        rec_acc_d   = rec_acc_q;
        mcand_d     = mcand_q;
        prod_d      = prod_q;
        neg_d       = neg_q;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    // Record fields are captured here and validated in FINISH;
                    // they are only compared in IDLE, so this is equivalent to
                    // writing the whole record at completion.
                    rec_f3_d  = funct3;
                    rec_rs1_d = rs1;
                    rec_rs2_d = rs2;
                    rec_acc_d = accuracy_control[10:0];
                    mcand_d   = mcand_eff;
                    prod_d    = {{XLEN{1'b0}}, rs2_mag};
                    neg_d     = rs1_neg ^ rs2_neg;
                    count_d   = '0;
                    busy_d    = 1'b1;
                    state_d   = S_CALC;
                end
            end
            S_CALC: begin
                prod_d  = prod_step;
                count_d = count_q + 1'b1;
                if (count_q == LAST_STEP) begin
                    state_d = S_FINISH;
                end
            end
            S_FINISH: begin
                out_d       = (rec_f3_q == 3'b000) ? prod_signed[XLEN-1:0]
                                                   : prod_signed[2*XLEN-1:XLEN];
                busy_d      = 1'b0;
                rec_valid_d = 1'b1;
                state_d     = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge CLK) begin
        if (reset) begin
            state_q     <= S_IDLE;
            count_q     <= '0;
            busy_q      <= 1'b0;
            out_q       <= '0;
            rec_valid_q <= 1'b0;
            rec_f3_q    <= '0;
            rec_rs1_q   <= '0;
            rec_rs2_q   <= '0;
            rec_acc_q   <= '0;
            mcand_q     <= '0;
            prod_q      <= '0;
            neg_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            count_q     <= count_d;
            busy_q      <= busy_d;
            out_q       <= out_d;
            rec_valid_q <= rec_valid_d;
            rec_f3_q    <= rec_f3_d;
            rec_rs1_q   <= rec_rs1_d;
            rec_rs2_q   <= rec_rs2_d;
            rec_acc_q   <= rec_acc_d;
            mcand_q     <= mcand_d;
            prod_q      <= prod_d;
            neg_q       <= neg_d;
        end
    end

    assign mul_unit_busy = busy_q;
    assign mul_output    = out_q;

endmodule

// File: tb/tb_multiplier_unit.sv
// tb_multiplier_unit
// Directed and randomized checks of multiplier_unit against a reference
// model that forms the product from signed/unsigned operand values with
// plain 64-bit arithmetic.
module tb_multiplier_unit;

    logic        CLK;
    logic        reset;
    logic [6:0]  opcode;
    logic [6:0]  funct7;
    logic [2:0]  funct3;
    logic [31:0] acc_ctl;
    logic [31:0] rs1;
    logic [31:0] rs2;
    logic        busy;
    logic [31:0] mul_out;

    int total = 0;
    int bad   = 0;

    multiplier_unit #(.XLEN(32), .STEPS(32)) dut (
        .CLK              (CLK),
        .reset            (reset),
        .opcode           (opcode),
        .funct7           (funct7),
        .funct3           (funct3),
        .accuracy_control (acc_ctl),
        .rs1              (rs1),
        .rs2              (rs2),
        .mul_unit_busy    (busy),
        .mul_output       (mul_out)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic logic [31:0] ref_mul(input logic [2:0] f3, input logic [31:0] a,
                                            input logic [31:0] b, input logic [31:0] acc);
        longint      sa, sb;
        logic [63:0] m1, m2, p;
        sa = ((f3 == 3'd1) || (f3 == 3'd2)) ? longint'($signed(a)) : longint'({32'b0, a});
        sb = (f3 == 3'd1) ? longint'($signed(b)) : longint'({32'b0, b});
        m1 = (sa < 0) ? 64'(-sa) : 64'(sa);
        m2 = (sb < 0) ? 64'(-sb) : 64'(sb);
        if (acc[0]) begin
            for (int i = 0; i < 8; i++) begin
                if (!acc[3+i]) m1[i] = 1'b0;
            end
        end
        p = m1 * m2;
        if ((sa < 0) != (sb < 0)) p = -p;
        return (f3 == 3'd0) ? p[31:0] : p[63:32];
    endfunction

    function automatic logic [31:0] rand_operand();
        case ($urandom_range(0, 7))
            0: return 32'h8000_0000;
            1: return 32'hFFFF_FFFF;
            2: return 32'h0000_0000;
            3: return 32'($urandom_range(0, 255));
            default: return 32'($urandom);
        endcase
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic set_op(input logic [2:0] f3, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] acc);
        opcode  = 7'b0110011;
        funct7  = 7'b0000001;
        funct3  = f3;
        rs1     = a;
        rs2     = b;
        acc_ctl = acc;
    endtask

    task automatic wait_start(input string tag);
        logic started;
        started = 1'b0;
        for (int k = 0; k < 6; k++) begin
            tick();
            if (busy) begin
                started = 1'b1;
                break;
            end
        end
        check({tag, "_start"}, {31'b0, started}, 32'd1);
    endtask

    // Counts busy samples, starting from a sample already seen high.
    task automatic finish_op(output int n);
        n = 1;
        for (int k = 0; k < 100; k++) begin
            tick();
            if (!busy) break;
            n++;
        end
    endtask

    task automatic run_op(input string tag, input logic [2:0] f3, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] acc, input logic [31:0] exp);
        int n;
        set_op(f3, a, b, acc);
        wait_start(tag);
        finish_op(n);
        check({tag, "_latency"}, 32'(n), 32'd33);
        check({tag, "_result"}, mul_out, exp);
    endtask

    task automatic expect_idle(input string tag, input int cycles, input logic [31:0] exp_out);
        logic seen;
        seen = 1'b0;
        for (int k = 0; k < cycles; k++) begin
            tick();
            if (busy) seen = 1'b1;
        end
        check({tag, "_no_busy"}, {31'b0, seen}, 32'd0);
        check({tag, "_held"}, mul_out, exp_out);
    endtask

    initial begin
        int          n;
        logic [2:0]  f3;
        logic [31:0] a, b, acc;
        logic [31:0] pa, pb, pacc;
        logic [2:0]  pf3;

        reset   = 1'b1;
        opcode  = 7'b0;
        funct7  = 7'b0;
        funct3  = 3'b0;
        rs1     = '0;
        rs2     = '0;
        acc_ctl = '0;
        repeat (3) tick();
        check("reset_busy", {31'b0, busy}, 32'd0);
        check("reset_out", mul_out, 32'd0);
        reset = 1'b0;
        expect_idle("post_reset", 5, 32'd0);

        // Exact MUL, then held operands must not retrigger.
        run_op("mul_exact", 3'b000, 32'd400, 32'd20, 32'h7F9, 32'd8000);
        expect_idle("mul_hold", 200, 32'd8000);

        // Approximation masks multiplicand bits 2:0 -> 100 becomes 96.
        run_op("mul_approx", 3'b000, 32'd100, 32'd20, 32'h7C1, 32'd1920);
        run_op("mul_approx_off", 3'b000, 32'd100, 32'd20, 32'h7C0, 32'd2000);

        run_op("mulh_neg", 3'b001, 32'hFFFF_FFFD, 32'd5, 32'h7F9, 32'hFFFF_FFFF);
        run_op("mulhu_max", 3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h7F9, 32'hFFFF_FFFE);
        run_op("mulhsu_m1", 3'b010, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h7F9, 32'hFFFF_FFFF);
        run_op("mulh_min", 3'b001, 32'h8000_0000, 32'h8000_0000, 32'h7F9, 32'h4000_0000);
        run_op("mul_zero", 3'b000, 32'd0, 32'd12345, 32'h0, 32'd0);

        // Operand change mid-operation: first result unaffected, then restart.
        set_op(3'b000, 32'd400, 32'd20, 32'h7F9);
        wait_start("chg");
        n = 1;
        for (int k = 0; k < 100; k++) begin
            tick();
            if (k == 9) rs2 = 32'd3;
            if (!busy) break;
            n++;
        end
        check("chg_first_latency", 32'(n), 32'd33);
        check("chg_first_result", mul_out, 32'd8000);
        tick();
        check("chg_gap_one_cycle", {31'b0, busy}, 32'd1);
        finish_op(n);
        check("chg_second_latency", 32'(n), 32'd33);
        check("chg_second_result", mul_out, 32'd1200);

        // Reset mid-operation aborts and clears everything.
        set_op(3'b000, 32'd123, 32'd456, 32'h7F9);
        wait_start("rst");
        repeat (15) tick();
        reset = 1'b1;
        set_op(3'b000, 32'd7, 32'd6, 32'h7F9);
        tick();
        check("rst_busy", {31'b0, busy}, 32'd0);
        check("rst_out", mul_out, 32'd0);
        reset = 1'b0;
        wait_start("rst_restart");
        finish_op(n);
        check("rst_restart_latency", 32'(n), 32'd33);
        check("rst_restart_result", mul_out, 32'd42);

        // Non-multiplier encodings never start; the record survives them.
        set_op(3'b100, 32'd99, 32'd77, 32'h7F9);
        expect_idle("div_f3", 40, 32'd42);
        set_op(3'b000, 32'd99, 32'd77, 32'h7F9);
        opcode = 7'b0010011;
        expect_idle("bad_opcode", 40, 32'd42);
        opcode = 7'b0110011;
        funct7 = 7'b0000000;
        expect_idle("bad_funct7", 40, 32'd42);
        set_op(3'b000, 32'd7, 32'd6, 32'h7F9);
        expect_idle("record_kept", 40, 32'd42);

        // Randomized operations against the reference model.
        pf3  = 3'b000;
        pa   = 32'd7;
        pb   = 32'd6;
        pacc = 32'h7F9;
        for (int t = 0; t < 40; t++) begin
            f3  = 3'($urandom_range(0, 3));
            a   = rand_operand();
            b   = rand_operand();
            acc = $urandom;
            if ($urandom_range(0, 1) == 0) acc[0] = 1'b0;
            if ({f3, a, b, acc[10:0]} == {pf3, pa, pb, pacc[10:0]}) a = a ^ 32'd1;
            run_op($sformatf("rand%0d", t), f3, a, b, acc, ref_mul(f3, a, b, acc));
            pf3  = f3;
            pa   = a;
            pb   = b;
            pacc = acc;
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/multiplier_unit.md
Name: multiplier_unit

Overview:
Iterative RV32M multiplier execution unit for MUL, MULH, MULHSU and MULHU. It forms the arithmetic counterpart of the divider unit and shares its operand and decode interface. It also shares the busy-stall contract, so the execute stage can drive either unit the same way. It supports the same accuracy_control scheme, which truncates low multiplicand bits when approximate mode is enabled.

Parameters:
XLEN, 32, operand/result width; only 32 is supported.
STEPS, 32, shift-add iterations per operation; must equal XLEN.

Ports:
CLK  input  1  rising-edge clock.
reset  input  1  synchronous, active-high reset.
opcode  input  7  instruction opcode; 0110011 selects the R-type path.
funct7  input  7  0000001 selects M-extension.
funct3  input  3  000 MUL, 001 MULH, 010 MULHSU, 011 MULHU; 1xx ignored (divider ops).
accuracy_control  input  32  [0] approximate enable; [10:3] truncation mask; others reserved.
rs1  input  32  multiplicand.
rs2  input  32  multiplier.
mul_unit_busy  output  1  high while an operation is in flight.
mul_output  output  32  result; holds last completed value.

Behaviour:
- Only one clock domain. Reset is synchronous and active-high: CLK and reset.
- Reset values: mul_unit_busy=0, mul_output=0, FSM=IDLE, last-op record invalid.
- Valid op: opcode==0110011 && funct7==0000001 && funct3[2]==0.
- Start condition: FSM==IDLE, valid op, and either the record is invalid or {funct3, rs1, rs2, accuracy_control[10:0]} differs from the record. This matches the divider contract: held operands do not retrigger.
- FSM states:
  - IDLE: on a start edge, latch the operands, compute magnitudes, set counter=0, set busy=1, go to CALC. Otherwise stay; outputs hold.
  - CALC: one radix-2 shift-add step per cycle on a 64-bit accumulator. Counter increments. After step 31, go to FINISH.
  - FINISH: apply sign correction, write mul_output, busy<=0, write the record (valid=1), go to IDLE.
- Latency: busy is high for exactly 33 cycles (32 CALC plus 1 FINISH). mul_output updates on the same edge that busy falls.
- Signedness:
  - MUL: both operands unsigned; output product[31:0].
  - MULH: both signed; output [63:32].
  - MULHSU: rs1 signed, rs2 unsigned; output [63:32].
  - MULHU: both unsigned; output [63:32].
  - Signed operands are converted to magnitude. The 64-bit product is two's-complement negated in FINISH when the operand signs differ.
  - The magnitude of 0x80000000 is 2^31, held in a 32-bit unsigned register.
- Approximation: if accuracy_control[0]==1, multiplicand magnitude bit i (i=0..7) is forced to 0 where accuracy_control[3+i]==0.
  - Applied before iteration, to the magnitude, not the raw operand.
  - With [0]==0, or mask==8'hFF, the result is exact.
- Inputs changing during CALC/FINISH are ignored because the operands are latched. After FINISH, the record compare against the current inputs restarts the unit if they differ.
- A valid op arriving while busy is not queued. It is re-evaluated in IDLE by the record compare.
- Invalid op or divider funct3: no start; outputs hold. The record is not cleared.
- Reset mid-operation: abort immediately on the reset edge, with all reset values. The next cycle starts a fresh operation if a valid op is present.
- rs1==0 or rs2==0: the full 33-cycle latency still applies and the result is 0; there is no early-out.

Test Plan:
- Exact MUL: acc=32'b11111111_001, rs1=400, rs2=20 → mul_output=8000; busy high for exactly 33 cycles, then low with output held for 200 cycles (no retrigger).
- Approximate MUL: acc=32'b11111000_001, rs1=100, rs2=20 → multiplicand becomes 96, mul_output=1920. Repeat with acc[0]=0 → 2000.
- MULH: rs1=-3 (0xFFFFFFFD), rs2=5 → 0xFFFFFFFF. Then MULHU, rs1=rs2=0xFFFFFFFF → 0xFFFFFFFE.
- MULHSU: rs1=0xFFFFFFFF (-1), rs2=0xFFFFFFFF → 0xFFFFFFFF. Then MULH with rs1=rs2=0x80000000 → 0x40000000.
- Operand change while busy: change rs2 20→3 at CALC cycle 10 with rs1=400. First result is 8000; busy drops for exactly 1 cycle, then a restart gives 1200 after 33 more cycles.
- Reset mid-op: assert reset at CALC cycle 15 → next cycle busy=0 and mul_output=0. Deassert with MUL 7×6 applied → 42 after 33 cycles. Also check funct3=100 input → no busy, output unchanged.
